// File: rtl/ysyx_25030093_lsu.sv
// Load/store unit: one instruction in flight, memory access over a req/rsp bus, single write-back beat.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word accesses skip memory and report wb_err.
module ysyx_25030093_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mem,
  input  logic                  in_store,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [31:0]           in_addr,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rsp_err,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_WIDTH-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  wb_wen,
  output logic                  wb_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              lane_q, lane_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    store_q, store_d;
  logic                    rd_wen_q, rd_wen_d;
  logic                    mem_req_valid_q, mem_req_valid_d;
  logic                    mem_wen_q, mem_wen_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_wstrb_q, mem_wstrb_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [ADDR_WIDTH-1:0]   wb_waddr_q, wb_waddr_d;
  logic [DATA_WIDTH-1:0]   wb_wdata_q, wb_wdata_d;
  logic                    wb_wen_q, wb_wen_d;
  logic                    wb_err_q, wb_err_d;

  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic        misalign;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((in_size == 2'b01) && in_addr[0]) || (in_size[1] && (in_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store data is replicated across lanes; the strobe picks the live bytes.
  always_comb begin
    case (in_size)
      2'b00: begin
        st_wdata = {4{in_result[7:0]}};
        st_wstrb = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_result[15:0]}};
        st_wstrb = 4'b0011 << {in_addr[1], 1'b0};
      end
      default: begin
        st_wdata = in_result;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    ld_b = mem_rdata[7:0];
      2'd1:    ld_b = mem_rdata[15:8];
      2'd2:    ld_b = mem_rdata[23:16];
      default: ld_b = mem_rdata[31:24];
    endcase
    ld_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_data = uns_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    lane_d          = lane_q;
    size_d          = size_q;
    uns_d           = uns_q;
    store_d         = store_q;
    rd_wen_d        = rd_wen_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_wen_d       = mem_wen_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    wb_valid_d      = wb_valid_q;
    wb_waddr_d      = wb_waddr_q;
    wb_wdata_d      = wb_wdata_q;
    wb_wen_d        = wb_wen_q;
    wb_err_d        = wb_err_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        lane_d     = in_addr[1:0];
        size_d     = in_size;
        uns_d      = in_unsigned;
        store_d    = in_store;
        rd_wen_d   = in_rd_wen;
        wb_waddr_d = in_rd;
        if (!in_mem) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_wdata_d = in_result;
          wb_wen_d   = in_rd_wen && (in_rd != '0);
          wb_err_d   = 1'b0;
        end else if (misalign) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_wdata_d = '0;
          wb_wen_d   = 1'b0;
          wb_err_d   = 1'b1;
        end else begin
          state_d         = REQ;
          mem_req_valid_d = 1'b1;
          mem_wen_d       = in_store;
          mem_addr_d      = {in_addr[31:2], 2'b00};
          mem_wdata_d     = in_store ? st_wdata : 32'b0;
          mem_wstrb_d     = in_store ? st_wstrb : 4'b0;
        end
      end
      REQ: if (mem_req_ready) begin
        state_d         = RESP;
        mem_req_valid_d = 1'b0;
        mem_wen_d       = 1'b0;
        mem_addr_d      = '0;
        mem_wdata_d     = '0;
        mem_wstrb_d     = '0;
      end
      RESP: if (mem_rsp_valid) begin
        state_d    = WB;
        wb_valid_d = 1'b1;
        wb_err_d   = mem_rsp_err;
        wb_wen_d   = rd_wen_q && (wb_waddr_q != '0) && !mem_rsp_err && !store_q;
        wb_wdata_d = (store_q || mem_rsp_err) ? '0 : ld_data;
      end
      WB: if (wb_ready) begin
        state_d    = IDLE;
        wb_valid_d = 1'b0;
        wb_waddr_d = '0;
        wb_wdata_d = '0;
        wb_wen_d   = 1'b0;
        wb_err_d   = 1'b0;
      end
    endcase
  end

  // Reset drops any in-flight access; a late response lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      lane_q          <= '0;
      size_q          <= '0;
      uns_q           <= 1'b0;
      store_q         <= 1'b0;
      rd_wen_q        <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_wen_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= '0;
      wb_valid_q      <= 1'b0;
      wb_waddr_q      <= '0;
      wb_wdata_q      <= '0;
      wb_wen_q        <= 1'b0;
      wb_err_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      lane_q          <= lane_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      store_q         <= store_d;
      rd_wen_q        <= rd_wen_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_wen_q       <= mem_wen_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      wb_valid_q      <= wb_valid_d;
      wb_waddr_q      <= wb_waddr_d;
      wb_wdata_q      <= wb_wdata_d;
      wb_wen_q        <= wb_wen_d;
      wb_err_q        <= wb_err_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = mem_req_valid_q;
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_waddr      = wb_waddr_q;
  assign wb_wdata      = wb_wdata_q;
  assign wb_wen        = wb_wen_q;
  assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Directed bench for ysyx_25030093_lsu: expected write-backs are queued at issue and popped at the WB beat.
module tb_ysyx_25030093_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_mem, in_store, in_unsigned, in_rd_wen;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_result;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid, mem_rsp_err;
  logic        wb_valid, wb_ready, wb_wen, wb_err;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  ysyx_25030093_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem(in_mem), .in_store(in_store),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_result(in_result),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_wen(wb_wen), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic        err;
    logic        chk_data;
  } wb_t;

  wb_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic w, input logic e, input logic cd);
    wb_t x;
    x.waddr = a; x.wdata = d; x.wen = w; x.err = e; x.chk_data = cd;
    sb.push_back(x);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic accept(input logic mem, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] res, input logic [4:0] rd, input logic rdw);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_mem = mem; in_store = st; in_size = sz; in_unsigned = uns;
    in_addr = addr; in_result = res; in_rd = rd; in_rd_wen = rdw;
    @(negedge clk);
    in_valid = 0; in_result = 32'h0; in_addr = 32'h0;
  endtask

  task automatic mem_phase(input logic [31:0] ea, input logic ew, input logic [31:0] ed, input logic [3:0] es,
                           input int stall, input logic [31:0] rdata, input logic err);
    for (int i = 0; i <= stall; i++) begin
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_addr, ea);
      chk("req_wen", mem_wen, ew);
      chk("req_wdata", mem_wdata, ed);
      chk("req_wstrb", mem_wstrb, es);
      chk("in_ready_req", in_ready, 0);
      if (i < stall) @(negedge clk);
    end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    chk("req_dropped", mem_req_valid, 0);
    mem_rsp_valid = 1; mem_rdata = rdata; mem_rsp_err = err;
    @(negedge clk);
    mem_rsp_valid = 0; mem_rdata = 32'h0; mem_rsp_err = 0;
  endtask

  task automatic wb_phase(input int max_wait, input int stall);
    wb_t e;
    int  w = 0;
    while (!wb_valid && w < max_wait) begin @(negedge clk); w++; end
    chk("wb_valid", wb_valid, 1);
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL sb_underflow: observed write-back with no expected entry");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i <= stall; i++) begin
      chk("wb_valid_hold", wb_valid, 1);
      chk("wb_waddr", wb_waddr, e.waddr);
      chk("wb_wen", wb_wen, e.wen);
      chk("wb_err", wb_err, e.err);
      if (e.chk_data) chk("wb_wdata", wb_wdata, e.wdata);
      chk("in_ready_wb", in_ready, 0);
      if (i < stall) @(negedge clk);
    end
    wb_ready = 1;
    @(negedge clk);
    wb_ready = 0;
    chk("wb_single_beat", wb_valid, 0);
    chk("in_ready_after_wb", in_ready, 1);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_mem = 0; in_store = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_result = 0; in_rd = 0; in_rd_wen = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; mem_rsp_err = 0; wb_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_wen", wb_wen, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    rst = 0;
    @(negedge clk);

    // Non-memory pass-through, wb one cycle after accept
    push(5, 32'h1234_5678, 1, 0, 1);
    accept(0, 0, 2'b10, 0, 32'h0, 32'h1234_5678, 5, 1);
    wb_phase(0, 0);

    // LB / LBU, top byte lane
    push(6, 32'hFFFF_FF80, 1, 0, 1);
    accept(1, 0, 2'b00, 0, 32'h8000_0003, 32'h0, 6, 1);
    mem_phase(32'h8000_0000, 0, 32'h0, 4'b0000, 0, 32'h80FF_FFFF, 0);
    wb_phase(0, 0);
    push(6, 32'h0000_0080, 1, 0, 1);
    accept(1, 0, 2'b00, 1, 32'h8000_0003, 32'h0, 6, 1);
    mem_phase(32'h8000_0000, 0, 32'h0, 4'b0000, 0, 32'h80FF_FFFF, 0);
    wb_phase(0, 0);

    // LB lane 1 positive
    push(12, 32'h0000_007F, 1, 0, 1);
    accept(1, 0, 2'b00, 0, 32'h8000_0001, 32'h0, 12, 1);
    mem_phase(32'h8000_0000, 0, 32'h0, 4'b0000, 0, 32'h0000_7F00, 0);
    wb_phase(0, 0);

    // SH upper half
    push(7, 32'h0, 0, 0, 1);
    accept(1, 1, 2'b01, 0, 32'h8000_0102, 32'hAAAA_BEEF, 7, 1);
    mem_phase(32'h8000_0100, 1, 32'hBEEF_BEEF, 4'b1100, 0, 32'h0, 0);
    wb_phase(0, 0);

    // SB lane 1, SW
    push(0, 32'h0, 0, 0, 1);
    accept(1, 1, 2'b00, 0, 32'h8000_0041, 32'h1234_56A5, 0, 1);
    mem_phase(32'h8000_0040, 1, 32'hA5A5_A5A5, 4'b0010, 0, 32'h0, 0);
    wb_phase(0, 0);
    push(3, 32'h0, 0, 0, 1);
    accept(1, 1, 2'b10, 0, 32'h8000_0044, 32'h0102_0304, 3, 1);
    mem_phase(32'h8000_0044, 1, 32'h0102_0304, 4'b1111, 0, 32'h0, 0);
    wb_phase(0, 0);

    // LH / LHU upper half
    push(13, 32'hFFFF_8001, 1, 0, 1);
    accept(1, 0, 2'b01, 0, 32'h8000_0002, 32'h0, 13, 1);
    mem_phase(32'h8000_0000, 0, 32'h0, 4'b0000, 0, 32'h8001_7FFF, 0);
    wb_phase(0, 0);
    push(13, 32'h0000_8001, 1, 0, 1);
    accept(1, 0, 2'b01, 1, 32'h8000_0002, 32'h0, 13, 1);
    mem_phase(32'h8000_0000, 0, 32'h0, 4'b0000, 0, 32'h8001_7FFF, 0);
    wb_phase(0, 0);

    // size 11 acts as word
    push(14, 32'h0BAD_F00D, 1, 0, 1);
    accept(1, 0, 2'b11, 0, 32'h8000_0048, 32'h0, 14, 1);
    mem_phase(32'h8000_0048, 0, 32'h0, 4'b0000, 0, 32'h0BAD_F00D, 0);
    wb_phase(0, 0);

    // Backpressure on both handshakes
    push(8, 32'hDEAD_BEEF, 1, 0, 1);
    accept(1, 0, 2'b10, 0, 32'h8000_0010, 32'h0, 8, 1);
    mem_phase(32'h8000_0010, 0, 32'h0, 4'b0000, 3, 32'hDEAD_BEEF, 0);
    wb_phase(0, 2);

    // LW to x0, bus error
    push(0, 32'h1111_2222, 0, 0, 1);
    accept(1, 0, 2'b10, 0, 32'h8000_0014, 32'h0, 0, 1);
    mem_phase(32'h8000_0014, 0, 32'h0, 4'b0000, 0, 32'h1111_2222, 0);
    wb_phase(0, 0);
    push(9, 32'h0, 0, 1, 0);
    accept(1, 0, 2'b10, 0, 32'h8000_0018, 32'h0, 9, 1);
    mem_phase(32'h8000_0018, 0, 32'h0, 4'b0000, 0, 32'h3333_4444, 1);
    wb_phase(0, 0);

    // Misaligned LW
`ifdef LSU_MISALIGN_CHECK_EN
    push(11, 32'h0, 0, 1, 0);
    accept(1, 0, 2'b10, 0, 32'h8000_0002, 32'h0, 11, 1);
    chk("mis_no_req", mem_req_valid, 0);
    wb_phase(0, 0);
`else
    push(11, 32'hCAFE_F00D, 1, 0, 1);
    accept(1, 0, 2'b10, 0, 32'h8000_0002, 32'h0, 11, 1);
    mem_phase(32'h8000_0000, 0, 32'h0, 4'b0000, 0, 32'hCAFE_F00D, 0);
    wb_phase(0, 0);
`endif

    // Reset while waiting for the response; late response must be ignored
    accept(1, 0, 2'b10, 0, 32'h8000_0020, 32'h0, 10, 1);
    chk("rr_req_valid", mem_req_valid, 1);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rr_in_ready", in_ready, 1);
    chk("rr_wb_valid", wb_valid, 0);
    chk("rr_req_valid_low", mem_req_valid, 0);
    mem_rsp_valid = 1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_rsp_valid = 0; mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("rr_no_wb", wb_valid, 0);
      chk("rr_idle", in_ready, 1);
      @(negedge clk);
    end

    // Still functional after the abort
    push(15, 32'hA5A5_0F0F, 1, 0, 1);
    accept(0, 0, 2'b10, 0, 32'h0, 32'hA5A5_0F0F, 15, 1);
    wb_phase(0, 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_25030093_lsu.md
# ysyx_25030093_lsu

Load/store unit that produces the write-back transactions consumed by the write-back unit (register file write port: `wdata`/`waddr`/`wen`). It accepts one executed instruction at a time from the execute stage, performs the memory access over a request/response bus when needed, aligns and extends load data, and presents a single write-back beat downstream. Non-memory instructions pass through with one register stage so every instruction reaches write-back through the same handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register/memory data width (only 32 supported)
- `ADDR_WIDTH`, 5, register-file address width

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk` in 1 clock
- `rst` in 1 synchronous active-high reset
- `in_valid` in 1 execute stage has an instruction
- `in_ready` out 1 LSU can accept (high only in IDLE)
- `in_mem` in 1 instruction is load/store
- `in_store` in 1 1=store, 0=load (valid when `in_mem`)
- `in_size` in 2 00=byte, 01=half, 10=word
- `in_unsigned` in 1 zero-extend load (LBU/LHU)
- `in_addr` in 32 effective byte address
- `in_result` in DATA_WIDTH ALU result (non-mem) / store data (store)
- `in_rd` in ADDR_WIDTH destination register
- `in_rd_wen` in 1 instruction writes `in_rd`
- `mem_req_valid` out 1, `mem_req_ready` in 1 request handshake
- `mem_wen` out 1, `mem_addr` out 32 (word-aligned), `mem_wdata` out 32, `mem_wstrb` out 4
- `mem_rsp_valid` in 1, `mem_rdata` in 32, `mem_rsp_err` in 1 response (no ready; LSU always accepts in RESP)
- `wb_valid` out 1, `wb_ready` in 1 write-back handshake
- `wb_waddr` out ADDR_WIDTH, `wb_wdata` out DATA_WIDTH, `wb_wen` out 1, `wb_err` out 1

## Operation
- States: IDLE, REQ, RESP, WB.
- IDLE: `in_ready`=1. On `in_valid`: latch all inputs. `in_mem`=0 → WB with `wb_wdata`=`in_result`. `in_mem`=1 → REQ.
- REQ: `mem_req_valid`=1, outputs stable until `mem_req_ready`; then → RESP.
- RESP: wait `mem_rsp_valid`; responses in any other state ignored. Then → WB.
  - Load: byte lane = `addr[1:0]`, half lane = `addr[1]`; sign-extend unless `in_unsigned`.
  - Store: `wb_wen`=0, `wb_wdata`=0.
  - `mem_rsp_err`=1: `wb_err`=1, `wb_wen`=0.
- WB: `wb_valid`=1, outputs held stable until `wb_ready`; then → IDLE.
- `wb_wen` = latched `in_rd_wen` & (`in_rd`≠0) & no error & not store.
- Store formatting: `mem_addr`={addr[31:2],2'b00}; byte: wdata = byte replicated ×4, wstrb=4'b0001<<addr[1:0]; half: wdata = half replicated ×2, wstrb=4'b0011<<{addr[1],1'b0}; word: wstrb=4'b1111. Loads drive `mem_wen`=0, `mem_wstrb`=0.
- `in_size`=11 treated as word.

## Timing
- Reset: state IDLE; `in_ready`=1; `mem_req_valid`, `wb_valid`, `wb_wen`, `wb_err`, `mem_wen`=0; all data/address outputs 0.
- Non-mem: accepted cycle N → `wb_valid` at N+1.
- Mem, zero-wait bus (`mem_req_ready`=1, response one cycle after accept): accept N, request N+1, response N+2, `wb_valid` N+3.
- Max one instruction in flight; `in_ready`=0 from accept until WB handshake completes (no same-cycle IDLE re-accept after WB).
- `wb_ready` stalls hold WB indefinitely; no output changes while stalled.
- Reset mid-transaction: abandon immediately, no write-back issued; a late `mem_rsp_valid` after reset is ignored.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: half with `addr[0]`=1 or word with `addr[1:0]`≠0 skips memory; IDLE → WB directly with `wb_err`=1, `wb_wen`=0.
- Undefined: no check; low address bits beyond the lane select are ignored (word uses aligned address, half uses `addr[1]` only); `wb_err` only from `mem_rsp_err`.

## Test plan
- Non-mem: `in_result`=0x1234_5678, rd=5 → one cycle later `wb_valid`=1, `wb_waddr`=5, `wb_wdata`=0x1234_5678, `wb_wen`=1.
- LB addr=0x8000_0003, `mem_rdata`=0x80FF_FFFF → `mem_addr`=0x8000_0000, `wb_wdata`=0xFFFF_FF80; same with LBU → 0x0000_0080.
- SH addr=0x8000_0102, data=0xAAAA_BEEF → `mem_wstrb`=4'b1100, `mem_wdata`=0xBEEF_BEEF, `wb_wen`=0, `wb_valid` after response.
- Backpressure: `mem_req_ready` low 3 cycles, `wb_ready` low 2 cycles → request and WB outputs stable, `in_ready`=0 throughout, exactly one write-back.
- LW rd=0 → `wb_wen`=0; `mem_rsp_err`=1 → `wb_err`=1, `wb_wen`=0.
- Misaligned LW addr=0x8000_0002 → with `LSU_MISALIGN_CHECK_EN`: no `mem_req_valid`, `wb_err`=1; without: request at 0x8000_0000. Also `rst` asserted in RESP → IDLE next cycle, no `wb_valid`.
